// File: rtl/fp_add_ctrl.sv
// rtl/fp_add_ctrl.sv - sequencing FSM for the floating-point adder datapath (optional op counter: FP_ADD_CTRL_PERF_CNT_EN)
module fp_add_ctrl #(
    parameter int SIZE     = 64,
    parameter int FRACTION = SIZE - 1 - (5 + ($clog2(SIZE) - 4) * 3),
    parameter int NORM_MAX = FRACTION + 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    output logic        o_ready,
    input  logic        i_denorm_done,
    input  logic        i_norm_done,
    output logic        o_en_des_norm,
    output logic        o_rst_n_des_norm,
    output logic        o_en_norm,
    output logic        o_rst_n_norm,
    output logic        o_mux_norm,
    output logic        o_load_result,
    output logic        o_valid,
    input  logic        i_ack,
    output logic        o_error,
    output logic        o_busy
`ifdef FP_ADD_CTRL_PERF_CNT_EN
    ,
    output logic [31:0] o_op_count
`endif
);

    localparam int CW = $clog2(NORM_MAX + 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(NORM_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DENORM,
        S_ADD,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_inc;
    logic            timeout;

    // Next-state decision; a done input beats the wait limit in the same cycle.
    always_comb begin
        state_nxt = state;
        timeout   = 1'b0;
        cnt_inc   = cnt + CW'(1);
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_nxt = S_DENORM;
                end
            end
            S_DENORM: begin
                if (i_denorm_done) begin
                    state_nxt = S_ADD;
                end else if (cnt_inc == CNT_LIMIT) begin
                    state_nxt = S_DONE;
                    timeout   = 1'b1;
                end
            end
            S_ADD: begin
                state_nxt = S_NORM;
            end
            S_NORM: begin
                if (i_norm_done) begin
                    state_nxt = S_ROUND;
                end else if (cnt_inc == CNT_LIMIT) begin
                    state_nxt = S_DONE;
                    timeout   = 1'b1;
                end
            end
            S_ROUND: begin
                state_nxt = S_DONE;
            end
            S_DONE: begin
                if (i_ack) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, wait counter, error flag and Moore outputs registered from the next state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state            <= S_IDLE;
            cnt              <= '0;
            o_error          <= 1'b0;
            o_ready          <= 1'b1;
            o_busy           <= 1'b0;
            o_en_des_norm    <= 1'b0;
            o_rst_n_des_norm <= 1'b0;
            o_en_norm        <= 1'b0;
            o_rst_n_norm     <= 1'b0;
            o_mux_norm       <= 1'b0;
            o_load_result    <= 1'b0;
            o_valid          <= 1'b0;
        end else begin
            state <= state_nxt;

            // Each wait phase starts counting from zero; only wait states advance it.
            if ((state_nxt != state) && ((state_nxt == S_DENORM) || (state_nxt == S_NORM))) begin
                cnt <= '0;
            end else if ((state == S_DENORM) || (state == S_NORM)) begin
                cnt <= cnt_inc;
            end

            // The error belongs to the current result, so it survives the ack until a new op starts.
            if ((state == S_IDLE) && i_start) begin
                o_error <= 1'b0;
            end else if (timeout) begin
                o_error <= 1'b1;
            end

            o_ready          <= (state_nxt == S_IDLE);
            o_busy           <= (state_nxt != S_IDLE);
            o_en_des_norm    <= (state_nxt == S_DENORM);
            o_rst_n_des_norm <= (state_nxt != S_IDLE);
            o_en_norm        <= (state_nxt == S_ADD) || (state_nxt == S_NORM);
            o_rst_n_norm     <= (state_nxt != S_IDLE);
            o_mux_norm       <= (state_nxt == S_ADD);
            o_load_result    <= (state_nxt == S_ROUND);
            o_valid          <= (state_nxt == S_DONE);
        end
    end

`ifdef FP_ADD_CTRL_PERF_CNT_EN
    // Count clean completions: DONE is entered without error only from ROUND.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_op_count <= '0;
        end else if (state == S_ROUND) begin
            o_op_count <= o_op_count + 32'd1;
        end
    end
`endif

endmodule
